// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcode table and FSM state encoding shared by ALU decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// muldiv_iter : one-bit-per-cycle unsigned shift-add multiply / restoring divide.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_busy,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [SHW-1:0] C_LAST = SHW'(WIDTH - 1);

  logic [SHW-1:0]   r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dsub;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_dsub  = w_shift - {1'b0, r_b};

  always_comb begin
    w_hi_nxt = w_msum[WIDTH:1];
    w_lo_nxt = {w_msum[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      // Borrow out of the WIDTH+1 bit subtract means the divisor did not fit.
      if (!w_dsub[WIDTH]) begin
        w_hi_nxt = w_dsub[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_is_div <= i_is_div;
      r_hi     <= '0;
      r_lo     <= i_a;
      r_b      <= i_b;
    end else if (i_busy) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  // hi/lo present the value after the current step so the final step's
  // result can be captured on the same edge that leaves BUSY.
  assign o_done = i_busy && (r_cnt == C_LAST);
  assign o_hi   = w_hi_nxt;
  assign o_lo   = w_lo_nxt;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : registered multicycle ALU with valid/ready handshakes and MULU/DIVU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic [1:0]       err
);

  localparam int MSB = WIDTH - 1;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_start, w_long, w_md_done;

  logic [WIDTH-1:0] w_md_hi, w_md_lo;
  logic [WIDTH-1:0] w_sum, w_diff, w_res, w_res_hi;
  logic             w_ovf;
  logic [1:0]       w_err;

  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_zero, r_neg, r_ovf;
  logic [1:0]       r_err;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_long = (op == OP_MULU) || ((op == OP_DIVU) && (b != '0));

  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_ovf    = 1'b0;
    w_err    = 2'b00;
    case (op)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRL:  w_res = b >> shamt;
      OP_SLL:  w_res = b << shamt;
      OP_SRA:  w_res = $signed(b) >>> shamt;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_MULU: w_res = '0;
      // Only reached on the single-cycle path, i.e. divide by zero.
      OP_DIVU: begin
        w_res    = '1;
        w_res_hi = a;
        w_err    = 2'b01;
      end
      default: w_err = 2'b10;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (w_long) begin
            w_start     = 1'b1;
            w_state_nxt = ST_BUSY;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_BUSY: if (w_md_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_busy   (r_state == ST_BUSY),
    .i_is_div (op == OP_DIVU),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_md_done),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 2'b00;
    end else if (w_accept && !w_long) begin
      r_result    <= w_res;
      r_result_hi <= w_res_hi;
      r_zero      <= (w_res == '0);
      r_neg       <= w_res[MSB];
      r_ovf       <= w_ovf;
      r_err       <= w_err;
    end else if (w_md_done) begin
      r_result    <= w_md_lo;
      r_result_hi <= w_md_hi;
      r_zero      <= (w_md_lo == '0);
      r_neg       <= w_md_lo[MSB];
      r_ovf       <= 1'b0;
      r_err       <= 2'b00;
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule

`default_nettype wire
